// File: rtl/mos6502_status_reg.sv
// MOS6502 processor status (P) register: flag updates from the ALU, PLP/RTI loads,
// BIT flags, set-overflow pin handling, stack push image and delayed IRQ mask.
module mos6502_status_reg #(
    parameter logic [7:0]  RESET_P = 8'h34,
    parameter int unsigned SO_SYNC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [3:0] P_OP,
    input  logic       ALU_COUT,
    input  logic       ALU_VOUT,
    input  logic       ALU_NOUT,
    input  logic       ALU_ZOUT,
    input  logic [7:0] DB_IN,
    input  logic       SO_n,
    input  logic       INSTR_END,
    input  logic       PUSH_B,
    output logic [7:0] P_out,
    output logic [7:0] P_push,
    output logic       C_flag,
    output logic       D_flag,
    output logic       I_mask
);

    localparam logic [3:0] OP_NZ   = 4'd1;
    localparam logic [3:0] OP_NZC  = 4'd2;
    localparam logic [3:0] OP_NVZC = 4'd3;
    localparam logic [3:0] OP_BIT  = 4'd4;
    localparam logic [3:0] OP_LOAD = 4'd5;
    localparam logic [3:0] OP_CLC  = 4'd6;
    localparam logic [3:0] OP_SEC  = 4'd7;
    localparam logic [3:0] OP_CLI  = 4'd8;
    localparam logic [3:0] OP_SEI  = 4'd9;
    localparam logic [3:0] OP_CLD  = 4'd10;
    localparam logic [3:0] OP_SED  = 4'd11;
    localparam logic [3:0] OP_CLV  = 4'd12;
    localparam logic [3:0] OP_INT  = 4'd13;

    logic n_q, v_q, d_q, i_q, z_q, c_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d;
    logic i_mask_q, i_mask_d;
    logic [SO_SYNC-1:0] so_sync_q, so_sync_d;
    logic so_last_q, so_last_d;
    logic so_pend_q, so_pend_d;
    logic so_fall;

    // B and bit-5 positions of a pulled byte have no storage
    logic unused_db;
    assign unused_db = ^DB_IN[5:4];

    always_comb begin
        n_d       = n_q;
        v_d       = v_q;
        d_d       = d_q;
        i_d       = i_q;
        z_d       = z_q;
        c_d       = c_q;
        i_mask_d  = i_mask_q;
        so_sync_d = {so_sync_q[SO_SYNC-2:0], SO_n};
        so_last_d = so_sync_q[SO_SYNC-1];
        so_fall   = so_last_q & ~so_sync_q[SO_SYNC-1];
        so_pend_d = so_pend_q;

        if (ce) begin
            so_pend_d = 1'b0;
            case (P_OP)
                OP_NZ:   begin n_d = ALU_NOUT; z_d = ALU_ZOUT; end
                OP_NZC:  begin n_d = ALU_NOUT; z_d = ALU_ZOUT; c_d = ALU_COUT; end
                OP_NVZC: begin
                    n_d = ALU_NOUT; v_d = ALU_VOUT; z_d = ALU_ZOUT; c_d = ALU_COUT;
                end
                OP_BIT:  begin n_d = DB_IN[7]; v_d = DB_IN[6]; z_d = ALU_ZOUT; end
                OP_LOAD: begin
                    n_d = DB_IN[7]; v_d = DB_IN[6]; d_d = DB_IN[3];
                    i_d = DB_IN[2]; z_d = DB_IN[1]; c_d = DB_IN[0];
                end
                OP_CLC:  c_d = 1'b0;
                OP_SEC:  c_d = 1'b1;
                OP_CLI:  i_d = 1'b0;
                OP_SEI:  i_d = 1'b1;
                OP_CLD:  d_d = 1'b0;
                OP_SED:  d_d = 1'b1;
                OP_CLV:  v_d = 1'b0;
                OP_INT:  i_d = 1'b1;
                default: ;
            endcase
            // Mask follows the pre-update I so CLI/SEI/PLP act one instruction late
            if (INSTR_END) i_mask_d = i_q;
            if (P_OP == OP_INT) i_mask_d = 1'b1;
            if (so_pend_q) v_d = 1'b1;
        end

        // A fresh SO edge survives a coincident ce; a second edge while pending merges
        if (so_fall) so_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q       <= RESET_P[7];
            v_q       <= RESET_P[6];
            d_q       <= RESET_P[3];
            i_q       <= RESET_P[2];
            z_q       <= RESET_P[1];
            c_q       <= RESET_P[0];
            i_mask_q  <= RESET_P[2];
            so_sync_q <= '1;
            so_last_q <= 1'b1;
            so_pend_q <= 1'b0;
        end else begin
            n_q       <= n_d;
            v_q       <= v_d;
            d_q       <= d_d;
            i_q       <= i_d;
            z_q       <= z_d;
            c_q       <= c_d;
            i_mask_q  <= i_mask_d;
            so_sync_q <= so_sync_d;
            so_last_q <= so_last_d;
            so_pend_q <= so_pend_d;
        end
    end

    assign P_out  = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
    assign P_push = {n_q, v_q, 1'b1, PUSH_B, d_q, i_q, z_q, c_q};
    assign C_flag = c_q;
    assign D_flag = d_q;
    assign I_mask = i_mask_q;

endmodule

// File: tb/tb_mos6502_status_reg.sv
// Bench for mos6502_status_reg: byte-level P model checked every cycle plus hand-computed vectors.
module tb_mos6502_status_reg;

    localparam int unsigned SYNC = 2;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic [3:0] P_OP;
    logic       ALU_COUT, ALU_VOUT, ALU_NOUT, ALU_ZOUT;
    logic [7:0] DB_IN;
    logic       SO_n;
    logic       INSTR_END;
    logic       PUSH_B;
    logic [7:0] P_out, P_push;
    logic       C_flag, D_flag, I_mask;

    int errors = 0;
    int checks = 0;
    bit run = 0;

    mos6502_status_reg #(.RESET_P(8'h34), .SO_SYNC(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .P_OP(P_OP),
        .ALU_COUT(ALU_COUT), .ALU_VOUT(ALU_VOUT), .ALU_NOUT(ALU_NOUT), .ALU_ZOUT(ALU_ZOUT),
        .DB_IN(DB_IN), .SO_n(SO_n), .INSTR_END(INSTR_END), .PUSH_B(PUSH_B),
        .P_out(P_out), .P_push(P_push), .C_flag(C_flag), .D_flag(D_flag), .I_mask(I_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: P as a byte (bits 5,4 always 1), SO pin as a delayed sample history
    logic [7:0] mp;
    bit         m_imask, m_pend;
    bit         hist [0:SYNC];

    always @(posedge clk or negedge rst_n) begin
        bit fall, old_i;
        if (!rst_n) begin
            mp = 8'h34; m_imask = 1'b1; m_pend = 1'b0;
            for (int k = 0; k <= SYNC; k++) hist[k] = 1'b1;
        end else begin
            fall  = hist[SYNC] && !hist[SYNC-1];
            old_i = mp[2];
            if (ce) begin
                case (P_OP)
                    4'd1:  begin mp[7] = ALU_NOUT; mp[1] = ALU_ZOUT; end
                    4'd2:  begin mp[7] = ALU_NOUT; mp[1] = ALU_ZOUT; mp[0] = ALU_COUT; end
                    4'd3:  begin mp[7] = ALU_NOUT; mp[6] = ALU_VOUT; mp[1] = ALU_ZOUT; mp[0] = ALU_COUT; end
                    4'd4:  begin mp[7:6] = DB_IN[7:6]; mp[1] = ALU_ZOUT; end
                    4'd5:  mp = DB_IN | 8'h30;
                    4'd6:  mp[0] = 1'b0;
                    4'd7:  mp[0] = 1'b1;
                    4'd8:  mp[2] = 1'b0;
                    4'd9:  mp[2] = 1'b1;
                    4'd10: mp[3] = 1'b0;
                    4'd11: mp[3] = 1'b1;
                    4'd12: mp[6] = 1'b0;
                    4'd13: mp[2] = 1'b1;
                    default: ;
                endcase
                if (m_pend) mp[6] = 1'b1;
                if (P_OP == 4'd13) m_imask = 1'b1;
                else if (INSTR_END) m_imask = old_i;
            end
            m_pend = fall ? 1'b1 : (ce ? 1'b0 : m_pend);
            for (int k = SYNC; k >= 1; k--) hist[k] = hist[k-1];
            hist[0] = SO_n;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("model P_out", P_out, mp);
            chk("model C_flag", 8'(C_flag), 8'(mp[0]));
            chk("model D_flag", 8'(D_flag), 8'(mp[3]));
            chk("model I_mask", 8'(I_mask), 8'(m_imask));
            chk("model P_push", P_push, {mp[7:6], 1'b1, PUSH_B, mp[3:0]});
        end
    end

    task automatic step(input logic c, input logic [3:0] op, input logic [3:0] nvzc,
                        input logic [7:0] db, input logic ie, input logic pb);
        ce = c; P_OP = op; {ALU_NOUT, ALU_VOUT, ALU_ZOUT, ALU_COUT} = nvzc;
        DB_IN = db; INSTR_END = ie; PUSH_B = pb;
        @(posedge clk); #2;
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; P_OP = 4'd0; {ALU_NOUT, ALU_VOUT, ALU_ZOUT, ALU_COUT} = 4'b0;
        DB_IN = 8'h00; SO_n = 1'b1; INSTR_END = 1'b0; PUSH_B = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run = 1'b1;

        chk("reset P_out", P_out, 8'h34);
        chk("reset I_mask", 8'(I_mask), 8'h01);
        chk("reset C_flag", 8'(C_flag), 8'h00);
        chk("reset D_flag", 8'(D_flag), 8'h00);
        step(1, 0, 4'b1111, 8'hFF, 0, 0);
        step(1, 0, 4'b1111, 8'hFF, 1, 0);
        chk("hold P_out", P_out, 8'h34);

        step(1, 3, 4'b1101, 8'h00, 0, 0);
        chk("nvzc P_out", P_out, 8'hF5);
        step(1, 2, 4'b1000, 8'h00, 0, 0);
        chk("nzc keeps V", P_out, 8'hF4);
        step(1, 3, 4'b1101, 8'h00, 0, 0);
        step(0, 0, 4'b0000, 8'h00, 0, 0);
        chk("push B=0", P_push, 8'hE5);
        PUSH_B = 1'b1; #1;
        chk("push B=1", P_push, 8'hF5);

        step(1, 5, 4'b1111, 8'h00, 1, 0);
        chk("load P_out", P_out, 8'h30);
        chk("load I_mask delayed", 8'(I_mask), 8'h01);
        step(1, 0, 4'b0000, 8'h00, 1, 0);
        chk("I_mask next instr", 8'(I_mask), 8'h00);

        step(1, 4, 4'b0010, 8'hC0, 0, 0);
        chk("bit P_out", P_out, 8'hF2);
        step(1, 12, 4'b0000, 8'h00, 0, 0);
        chk("clv P_out", P_out, 8'hB2);

        SO_n = 1'b0;
        repeat (5) step(0, 0, 4'b0000, 8'h00, 0, 0);
        chk("so waits for ce", P_out, 8'hB2);
        step(1, 12, 4'b0000, 8'h00, 0, 0);
        chk("so beats clv", P_out, 8'hF2);
        step(1, 12, 4'b0000, 8'h00, 0, 0);
        chk("so pend cleared", P_out, 8'hB2);

        SO_n = 1'b1;
        repeat (4) step(0, 0, 4'b0000, 8'h00, 0, 0);
        SO_n = 1'b0;
        repeat (6) step(1, 0, 4'b0000, 8'h00, 0, 0);
        chk("so with ce running", P_out, 8'hF2);

        step(1, 13, 4'b0000, 8'h00, 0, 0);
        chk("int P_out", P_out, 8'hF6);
        chk("int I_mask", 8'(I_mask), 8'h01);
        step(1, 8, 4'b0000, 8'h00, 1, 0);
        chk("cli P_out", P_out, 8'hF2);
        chk("cli I_mask delayed", 8'(I_mask), 8'h01);
        step(1, 0, 4'b0000, 8'h00, 1, 0);
        chk("cli I_mask later", 8'(I_mask), 8'h00);

        step(0, 7, 4'b1111, 8'hFF, 1, 0);
        chk("ce low ignored", P_out, 8'hF2);
        step(1, 14, 4'b1111, 8'hFF, 0, 0);
        step(1, 15, 4'b1111, 8'hFF, 0, 0);
        chk("reserved hold", P_out, 8'hF2);
        step(1, 11, 4'b0000, 8'h00, 0, 0);
        chk("sed P_out", P_out, 8'hFA);
        chk("sed D_flag", 8'(D_flag), 8'h01);
        step(1, 7, 4'b0000, 8'h00, 0, 0);
        chk("sec P_out", P_out, 8'hFB);
        step(1, 6, 4'b0000, 8'h00, 0, 1);
        step(1, 10, 4'b0000, 8'h00, 0, 1);
        step(1, 9, 4'b0000, 8'h00, 0, 0);
        chk("sei P_out", P_out, 8'hF6);
        step(1, 1, 4'b0000, 8'h00, 0, 0);
        chk("nz P_out", P_out, 8'h74);
        step(1, 5, 4'b0000, 8'hCF, 1, 1);
        chk("load all P_out", P_out, 8'hFF);

        SO_n = 1'b1;
        repeat (4) step(0, 0, 4'b0000, 8'h00, 0, 0);
        step(1, 12, 4'b0000, 8'h00, 0, 0);
        SO_n = 1'b0;
        repeat (4) step(0, 0, 4'b0000, 8'h00, 0, 0);
        ce = 1'b1; P_OP = 4'd7;
        #1 rst_n = 1'b0;
        #1;
        chk("async reset P_out", P_out, 8'h34);
        chk("async reset I_mask", 8'(I_mask), 8'h01);
        SO_n = 1'b1;
        @(posedge clk); #2 rst_n = 1'b1;
        step(1, 0, 4'b0000, 8'h00, 0, 0);
        chk("pend lost on reset", P_out, 8'h34);
        repeat (3) step(1, 0, 4'b0000, 8'h00, 1, 0);

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
